isolde_vlen_decoder: RTL

ISOLDE_VLEN_DECODER -- requirements
Module: isolde_vlen_decoder

---
 rtl/isolde_vlen_decoder.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/isolde_vlen_decoder.sv
// Assembles variable-length instructions (1..MAX_WORDS words) from a fetch word stream.
// Define ISOLDE_VLEN_TIMEOUT_EN to abort partial instructions after TIMEOUT_CYCLES idle cycles.
module isolde_vlen_decoder #(
    parameter int unsigned MAX_WORDS      = 5,
    parameter int unsigned WORD_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned LW = $clog2(MAX_WORDS + 1),
    localparam int unsigned IW = MAX_WORDS * WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_word_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [IW-1:0]     out_instr_o,
    output logic [LW-1:0]     out_len_o,
    output logic              illegal_o,
    output logic              timeout_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSEMBLE = 2'd1,
        HOLD     = 2'd2
    } state_e;

    // An out-of-range configuration keeps the input side closed forever.
    localparam bit CFG_OK = (MAX_WORDS >= 1) && (MAX_WORDS <= 8) &&
                            (WORD_W >= 32) && (TIMEOUT_CYCLES >= 1);

    state_e          state_r, state_s;
    logic [LW-1:0]   cnt_r, cnt_s;
    logic [LW-1:0]   len_r, len_s;
    logic [IW-1:0]   buf_r, buf_s;
    logic            alive_r;

    logic            out_valid_r, out_valid_s;
    logic [IW-1:0]   out_instr_r, out_instr_s;
    logic [LW-1:0]   out_len_r, out_len_s;
    logic            illegal_r, illegal_s;
    logic            timeout_r, timeout_s;

    logic [3:0]      first_len_s;
    logic            first_legal_s;
    logic            first_single_s;
    logic            free_s;
    logic            last_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            tmo_hit_s;
    logic [IW-1:0]   first_buf_s;
    logic [IW-1:0]   merged_s;

    // First-word decode, output-register availability and input handshake.
    always_comb begin
        first_len_s    = 4'd1 + {1'b0, in_word_i[27:25]};
        first_legal_s  = ((in_word_i[6:0] == 7'h0B) || (in_word_i[6:0] == 7'h2B)) &&
                         (first_len_s <= 4'(MAX_WORDS));
        first_single_s = first_legal_s && (first_len_s == 4'd1);
        free_s         = !out_valid_r || out_ready_i;
        last_s         = ((cnt_r + LW'(1)) == len_r);
        // A completing L=1 word cannot be parked, so IDLE stalls it; a multi-word
        // last word is parked in HOLD instead.
        case (state_r)
            IDLE:     in_ready_s = alive_r && !(first_single_s && !free_s);
            ASSEMBLE: in_ready_s = alive_r;
            HOLD:     in_ready_s = 1'b0;
            default:  in_ready_s = 1'b0;
        endcase
        accept_s = in_valid_i && in_ready_s;
    end

    // Candidate buffer contents: a fresh instruction, or the current one plus this word.
    always_comb begin
        first_buf_s                = '0;
        first_buf_s[WORD_W-1:0]    = in_word_i;
        merged_s                   = buf_r;
        for (int k = 0; k < int'(MAX_WORDS); k++) begin
            if (cnt_r == LW'(k)) begin
                merged_s[k*WORD_W +: WORD_W] = in_word_i;
            end else begin
                merged_s[k*WORD_W +: WORD_W] = buf_r[k*WORD_W +: WORD_W];
            end
        end
    end

`ifdef ISOLDE_VLEN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_r;

    assign tmo_hit_s = (state_r == ASSEMBLE) && !accept_s &&
                       (tcnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Consecutive idle cycles spent in ASSEMBLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_r <= '0;
        end else if (flush_i || (state_r != ASSEMBLE) || accept_s || tmo_hit_s) begin
            tcnt_r <= '0;
        end else begin
            tcnt_r <= tcnt_r + TW'(1);
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // FSM next state, word counter and assembly buffer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        len_s   = len_r;
        buf_s   = buf_r;
        if (flush_i) begin
            state_s = IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && first_legal_s && !first_single_s) begin
                        state_s = ASSEMBLE;
                        cnt_s   = LW'(1);
                        len_s   = LW'(first_len_s);
                        buf_s   = first_buf_s;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ASSEMBLE: begin
                    if (tmo_hit_s) begin
                        state_s = IDLE;
                        cnt_s   = '0;
                        buf_s   = '0;
                    end else if (accept_s) begin
                        buf_s = merged_s;
                        if (last_s) begin
                            cnt_s   = '0;
                            state_s = free_s ? IDLE : HOLD;
                        end else begin
                            cnt_s = cnt_r + LW'(1);
                        end
                    end else begin
                        state_s = ASSEMBLE;
                    end
                end
                HOLD: begin
                    if (free_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // Output register load/drain and status pulses.
    always_comb begin
        out_valid_s = out_valid_r;
        out_instr_s = out_instr_r;
        out_len_s   = out_len_r;
        illegal_s   = 1'b0;
        timeout_s   = 1'b0;
        if (flush_i) begin
            out_valid_s = 1'b0;
        end else begin
            if (out_valid_r && out_ready_i) begin
                out_valid_s = 1'b0;
            end else begin
                out_valid_s = out_valid_r;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s && first_single_s) begin
                        out_valid_s = 1'b1;
                        out_instr_s = first_buf_s;
                        out_len_s   = LW'(1);
                    end else if (accept_s && !first_legal_s) begin
                        illegal_s = 1'b1;
                    end else begin
                        illegal_s = 1'b0;
                    end
                end
                ASSEMBLE: begin
                    if (accept_s && last_s && free_s) begin
                        out_valid_s = 1'b1;
                        out_instr_s = merged_s;
                        out_len_s   = len_r;
                    end else begin
                        out_valid_s = out_valid_s;
                    end
                    timeout_s = tmo_hit_s;
                end
                HOLD: begin
                    if (free_s) begin
                        out_valid_s = 1'b1;
                        out_instr_s = buf_r;
                        out_len_s   = len_r;
                    end else begin
                        out_valid_s = out_valid_s;
                    end
                end
                default: begin
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            len_r   <= '0;
            buf_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            len_r   <= len_s;
            buf_r   <= buf_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_r <= 1'b0;
            out_instr_r <= '0;
            out_len_r   <= '0;
            illegal_r   <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            out_valid_r <= out_valid_s;
            out_instr_r <= out_instr_s;
            out_len_r   <= out_len_s;
            illegal_r   <= illegal_s;
            timeout_r   <= timeout_s;
        end
    end

    // Opens the input one cycle after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= CFG_OK;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_r;
    assign out_instr_o = out_instr_r;
    assign out_len_o   = out_len_r;
    assign illegal_o   = illegal_r;
    assign timeout_o   = timeout_r;
    assign busy_o      = (state_r != IDLE) || out_valid_r;

endmodule
